// File: rtl/mult_div_pkg.sv
// Shared constants and state encoding for the sequential multiply/divide unit.
package mult_div_pkg;
   localparam int WIDTH    = 32;
   localparam int ITER_CNT = WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_FIX  = 2'd2
   } state_t;
endpackage

// File: rtl/sign_fix.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign correction.
module sign_fix #(
   parameter int W = 32
) (
   input  logic         i_neg,
   input  logic [W-1:0] i_val,
   output logic [W-1:0] o_val
);
   assign o_val = i_neg ? ({W{1'b0}} - i_val) : i_val;
endmodule

// File: rtl/mult_div_unit.sv
// Sequential one-bit-per-clock multiply/divide unit sharing a single 2*WIDTH accumulator.
// Results land in Hi/Lo with a one-cycle Done pulse.
module mult_div_unit #(
   parameter int WIDTH = mult_div_pkg::WIDTH
) (
   input  logic             clock,
   input  logic             Reset,
   input  logic             MultCtrl,
   input  logic             DivCtrl,
   input  logic             IsUnsigned,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo,
   output logic             Busy,
   output logic             Done,
   output logic             DivZero
);
   import mult_div_pkg::*;

   localparam int               CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   state_t               r_state, w_state_nxt;
   logic [CNT_W-1:0]     r_cnt;
   logic [2*WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]     r_opb;
   logic [WIDTH-1:0]     r_hi, r_lo;
   logic                 r_is_div, r_dz, r_neg_q, r_neg_r;
   logic                 r_busy, r_done, r_div_zero;

   logic                 w_start, w_div, w_b_zero, w_a_neg, w_b_neg, w_q_bit;
   logic [WIDTH-1:0]     w_a_mag, w_b_mag, w_rem_sub, w_quo, w_rem;
   logic [WIDTH:0]       w_mul_sum, w_rem_sh;
   logic [2*WIDTH-1:0]   w_mul_acc, w_div_acc, w_prod;

   assign w_start  = MultCtrl | DivCtrl;
   assign w_div    = DivCtrl & ~MultCtrl;
   assign w_b_zero = (B == '0);
   assign w_a_neg  = ~IsUnsigned & A[WIDTH-1];
   assign w_b_neg  = ~IsUnsigned & B[WIDTH-1];

   sign_fix #(.W(WIDTH)) u_mag_a (.i_neg(w_a_neg), .i_val(A), .o_val(w_a_mag));
   sign_fix #(.W(WIDTH)) u_mag_b (.i_neg(w_b_neg), .i_val(B), .o_val(w_b_mag));

   // Multiply: {hi,lo} with multiplier in lo; add multiplicand into hi, shift right with carry.
   assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
   assign w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};

   // Divide: {rem,quot}; shifted remainder needs one extra bit before the compare.
   assign w_rem_sh  = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_q_bit   = (w_rem_sh >= {1'b0, r_opb});
   assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_opb;
   assign w_div_acc = {(w_q_bit ? w_rem_sub : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_q_bit};

   sign_fix #(.W(2*WIDTH)) u_fix_p (.i_neg(r_neg_q), .i_val(r_acc), .o_val(w_prod));
   sign_fix #(.W(WIDTH))   u_fix_q (.i_neg(r_neg_q), .i_val(r_acc[WIDTH-1:0]), .o_val(w_quo));
   sign_fix #(.W(WIDTH))   u_fix_r (.i_neg(r_neg_r), .i_val(r_acc[2*WIDTH-1:WIDTH]), .o_val(w_rem));

   always_ff @(posedge clock) begin
      if (Reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: if (w_start) w_state_nxt = (w_div && w_b_zero) ? ST_FIX : ST_ITER;
         ST_ITER: if (r_cnt == LAST) w_state_nxt = ST_FIX;
         ST_FIX:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (Reset) begin
         r_cnt      <= '0;
         r_acc      <= '0;
         r_opb      <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_is_div   <= 1'b0;
         r_dz       <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            ST_IDLE: if (w_start) begin
               r_is_div   <= w_div;
               r_dz       <= w_div & w_b_zero;
               r_neg_q    <= ~IsUnsigned & (A[WIDTH-1] ^ B[WIDTH-1]);
               r_neg_r    <= w_div & w_a_neg;
               r_acc      <= {{WIDTH{1'b0}}, w_a_mag};
               r_opb      <= w_b_mag;
               r_cnt      <= '0;
               r_div_zero <= 1'b0;
               r_busy     <= 1'b1;
            end
            ST_ITER: begin
               r_acc <= r_is_div ? w_div_acc : w_mul_acc;
               r_cnt <= r_cnt + 1'b1;
            end
            ST_FIX: begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
               if (r_dz) begin
                  r_div_zero <= 1'b1;
               end else if (r_is_div) begin
                  r_hi <= w_rem;
                  r_lo <= w_quo;
               end else begin
                  {r_hi, r_lo} <= w_prod;
               end
            end
            default: ;
         endcase
      end
   end

   assign Hi      = r_hi;
   assign Lo      = r_lo;
   assign Busy    = r_busy;
   assign Done    = r_done;
   assign DivZero = r_div_zero;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected Hi/Lo/DivZero queued at start, compared on Done.
module tb_mult_div_unit;
   localparam int W = 32;

   logic         clock = 1'b0;
   logic         Reset = 1'b1;
   logic         MultCtrl = 1'b0, DivCtrl = 1'b0, IsUnsigned = 1'b0;
   logic [W-1:0] A = '0, B = '0;
   logic [W-1:0] Hi, Lo;
   logic         Busy, Done, DivZero;

   always #5 clock = ~clock;

   mult_div_unit #(.WIDTH(W)) dut (
      .clock(clock), .Reset(Reset), .MultCtrl(MultCtrl), .DivCtrl(DivCtrl),
      .IsUnsigned(IsUnsigned), .A(A), .B(B), .Hi(Hi), .Lo(Lo),
      .Busy(Busy), .Done(Done), .DivZero(DivZero)
   );

   typedef struct packed {
      logic         dz;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } exp_t;

   exp_t         q_exp[$];
   int           n_chk = 0, n_err = 0;
   logic [W-1:0] m_hi = '0, m_lo = '0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   function automatic exp_t model(input bit mul, input bit uns, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input logic [W-1:0] phi,
                                  input logic [W-1:0] plo);
      exp_t        e;
      longint      sa, sd, p;
      logic [63:0] u, t;
      e.dz = 1'b0;
      if (mul) begin
         if (uns) u = {32'b0, a} * {32'b0, b};
         else begin
            p = longint'($signed(a)) * longint'($signed(b));
            u = p;
         end
         e.hi = u[63:32];
         e.lo = u[31:0];
      end else if (b == 0) begin
         e.dz = 1'b1;
         e.hi = phi;
         e.lo = plo;
      end else if (uns) begin
         e.lo = a / b;
         e.hi = a % b;
      end else begin
         sa = longint'($signed(a));
         sd = longint'($signed(b));
         t = sa / sd;
         e.lo = t[31:0];
         t = sa % sd;
         e.hi = t[31:0];
      end
      return e;
   endfunction

   // Called at a negedge; start is sampled at the following posedge.
   task automatic op_start(input bit mul, input bit div, input bit uns,
                           input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      MultCtrl = mul; DivCtrl = div; IsUnsigned = uns; A = a; B = b;
      e = model(mul, uns, a, b, m_hi, m_lo);
      q_exp.push_back(e);
      m_hi = e.hi;
      m_lo = e.lo;
      @(posedge clock);
      @(negedge clock);
      MultCtrl = 1'b0;
      DivCtrl  = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int exp_lat, input bit chk_busy);
      int lat = 0, nb = 0;
      if (Busy) nb++;
      while (!Done && lat < 60) begin
         @(negedge clock);
         lat++;
         if (Busy) nb++;
      end
      chk({tag, "_lat"}, lat, exp_lat);
      if (chk_busy) begin
         chk({tag, "_busy_cycles"}, nb, 33);
         chk({tag, "_busy_at_done"}, Busy, 0);
      end
   endtask

   always @(negedge clock) begin
      if (!Reset && Done) begin
         if (q_exp.size() == 0) chk("unexpected_done", 1, 0);
         else begin
            exp_t e;
            e = q_exp.pop_front();
            chk("sb_hi", Hi, e.hi);
            chk("sb_lo", Lo, e.lo);
            chk("sb_divzero", DivZero, e.dz);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int seen;
      repeat (3) @(negedge clock);
      chk("rst_hi", Hi, 0);
      chk("rst_lo", Lo, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_done", Done, 0);
      chk("rst_divzero", DivZero, 0);
      Reset = 1'b0;
      @(negedge clock);

      op_start(1, 0, 0, 32'd7, 32'hFFFF_FFFD);
      wait_done("smul", 33, 1);
      chk("smul_hi", Hi, 32'hFFFF_FFFF);
      chk("smul_lo", Lo, 32'hFFFF_FFEB);
      @(negedge clock);
      chk("done_one_cycle", Done, 0);
      chk("hold_lo", Lo, 32'hFFFF_FFEB);

      op_start(1, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("umul", 33, 1);
      chk("umul_hi", Hi, 32'hFFFF_FFFE);
      chk("umul_lo", Lo, 32'h0000_0001);
      op_start(1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("smul_m1", 33, 0);

      op_start(0, 1, 0, 32'hFFFF_FFF9, 32'd2);
      wait_done("sdiv", 33, 0);
      chk("sdiv_lo", Lo, 32'hFFFF_FFFD);
      chk("sdiv_hi", Hi, 32'hFFFF_FFFF);
      op_start(0, 1, 1, 32'd100, 32'd7);
      wait_done("udiv", 33, 0);
      op_start(0, 1, 1, 32'h5678_1234, 32'h0001_0000);
      wait_done("udiv_prior", 33, 0);
      chk("prior_hi", Hi, 32'h1234);
      chk("prior_lo", Lo, 32'h5678);

      op_start(0, 1, 0, 32'd100, 32'd0);
      wait_done("dz", 1, 0);
      chk("dz_flag", DivZero, 1);
      chk("dz_hi_hold", Hi, 32'h1234);
      chk("dz_lo_hold", Lo, 32'h5678);
      repeat (3) @(negedge clock);
      chk("dz_sticky", DivZero, 1);

      op_start(0, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("dz_cleared", DivZero, 0);
      wait_done("ovf", 33, 0);
      chk("ovf_lo", Lo, 32'h8000_0000);
      chk("ovf_hi", Hi, 32'h0);

      op_start(1, 1, 0, 32'hFFFE_DCBA, 32'h0000_0100);
      wait_done("both", 33, 0);

      // Abort a multiply while the iteration counter reads 10.
      op_start(1, 0, 1, 32'hDEAD_BEEF, 32'h1234_5678);
      repeat (10) @(negedge clock);
      Reset = 1'b1;
      @(negedge clock);
      q_exp.delete();
      m_hi = '0;
      m_lo = '0;
      chk("abort_hi", Hi, 0);
      chk("abort_lo", Lo, 0);
      chk("abort_busy", Busy, 0);
      chk("abort_done", Done, 0);
      Reset = 1'b0;
      seen = 0;
      repeat (40) begin
         @(negedge clock);
         if (Done) seen++;
      end
      chk("abort_no_done", seen, 0);

      op_start(1, 0, 0, 32'hFFFF_0001, 32'h7FFF_FFFF);
      repeat (4) @(negedge clock);
      DivCtrl = 1'b1;
      B = '0;
      @(negedge clock);
      DivCtrl = 1'b0;
      wait_done("ign_div", 28, 0);
      @(negedge clock);
      chk("ign_divzero", DivZero, 0);

      op_start(0, 1, 0, 32'hFFFF_FC18, 32'd3);
      wait_done("b2b_first", 33, 0);
      op_start(1, 0, 1, 32'd5, 32'd6);
      wait_done("b2b_second", 33, 0);

      repeat (40) @(negedge clock);
      chk("sb_empty", q_exp.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
